// File: rtl/ei_axi4_pkg.sv
// Shared AXI4 types and checker error encoding for the ei_axi4 block.
package ei_axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_type_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } response_e;

  localparam int NUM_CHK_ERR = 12;

  // Bit positions in err_flags; also the values reported on first_err.
  typedef enum logic [3:0] {
    ERR_AW_STABLE     = 4'd0,
    ERR_W_STABLE      = 4'd1,
    ERR_AR_STABLE     = 4'd2,
    ERR_WLAST         = 4'd3,
    ERR_RLAST         = 4'd4,
    ERR_W_NO_AW       = 4'd5,
    ERR_B_UNEXP       = 4'd6,
    ERR_R_UNEXP       = 4'd7,
    ERR_BURST_ILLEGAL = 4'd8,
    ERR_SIZE_ILLEGAL  = 4'd9,
    ERR_OVERFLOW      = 4'd10,
    ERR_TIMEOUT       = 4'd11
  } ei_axi4_chk_err_e;

  // Reserved burst type, or WRAP with a bad length or an address not aligned to the beat size.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len,
                                     input logic [2:0] size, input logic [6:0] addr_lo);
    logic [6:0] mask;
    mask = 7'((8'd1 << size) - 8'd1);
    if (burst == BURST_RSVD) return 1'b1;
    if (burst == BURST_WRAP)
      return !(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || ((addr_lo & mask) != 7'd0);
    return 1'b0;
  endfunction

  // Lowest set index of an error vector (0 when empty).
  function automatic logic [3:0] first_idx(input logic [NUM_CHK_ERR-1:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = NUM_CHK_ERR-1; i >= 0; i--)
      if (v[i]) r = 4'(i);
    return r;
  endfunction

endpackage

// File: rtl/ei_axi4_len_fifo.sv
// Small FIFO of burst lengths for outstanding address-channel transactions.
// A pop is honoured first, so a push into a full FIFO in the same cycle still lands.
module ei_axi4_len_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               rd_ptr, wr_ptr;
  logic                        do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers and occupancy.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ei_axi4_protocol_checker.sv
// Passive AXI4 link checker: sticky error flags, first-error capture and completion counters.
module ei_axi4_protocol_checker
  import ei_axi4_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int STALL_TIMEOUT   = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  input  logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  input  logic                    rready,
  input  logic                    err_clr,
  output logic [11:0]             err_flags,
  output logic [3:0]              first_err,
  output logic                    err_pulse,
  output logic [31:0]             wr_done_cnt,
  output logic [31:0]             rd_done_cnt
);
  localparam int CW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int TW  = $clog2(STALL_TIMEOUT + 1);
  localparam int AXP = ADDR_WIDTH + 13;
  localparam int WP  = DATA_WIDTH + DATA_WIDTH/8 + 1;
  localparam int NCH = 5;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;
  assign b_hs  = bvalid  && bready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid  && rready;

  // ---------------- write side bookkeeping ----------------
  logic          aw_full, aw_empty, aw_avail, aw_fifo_push, aw_fifo_pop, aw_ovf;
  logic [CW-1:0] aw_count, bpend;
  logic [7:0]    aw_head, aw_cur_len, w_beat;
  logic          w_at_last, w_pop, b_ok;

  // A same-cycle AW handshake makes its length visible to the W beat (pass-through).
  assign aw_avail     = !aw_empty || aw_hs;
  assign aw_cur_len   = aw_empty ? awlen : aw_head;
  assign w_at_last    = (w_beat == aw_cur_len);
  assign w_pop        = w_hs && aw_avail && w_at_last;
  assign aw_fifo_pop  = w_pop && !aw_empty;
  assign aw_fifo_push = aw_hs && !(aw_empty && w_pop) && (!aw_full || aw_fifo_pop);
  assign aw_ovf       = aw_hs && (aw_count == CW'(MAX_OUTSTANDING)) && !aw_fifo_pop;
  assign b_ok         = b_hs && (bpend != '0);

  ei_axi4_len_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(8)) u_aw_fifo (
    .aclk(aclk), .aresetn(aresetn), .push(aw_fifo_push), .pop(aw_fifo_pop), .din(awlen),
    .full(aw_full), .empty(aw_empty), .count(aw_count), .head(aw_head)
  );

  // ---------------- read side bookkeeping ----------------
  logic          ar_full, ar_empty, ar_fifo_push, r_at_last, r_pop, ar_ovf;
  logic [CW-1:0] ar_count;
  logic [7:0]    ar_head, r_beat;

  assign r_at_last    = (r_beat == ar_head);
  assign r_pop        = r_hs && !ar_empty && r_at_last;
  assign ar_fifo_push = ar_hs && (!ar_full || r_pop);
  assign ar_ovf       = ar_hs && (ar_count == CW'(MAX_OUTSTANDING)) && !r_pop;

  ei_axi4_len_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(8)) u_ar_fifo (
    .aclk(aclk), .aresetn(aresetn), .push(ar_fifo_push), .pop(r_pop), .din(arlen),
    .full(ar_full), .empty(ar_empty), .count(ar_count), .head(ar_head)
  );

  // Beat counters, pending-B counter and completion counters. Pops happen at beat len
  // whatever the last bit says, which resynchronises after a wlast/rlast error.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_beat      <= '0;
      r_beat      <= '0;
      bpend       <= '0;
      wr_done_cnt <= '0;
      rd_done_cnt <= '0;
    end else begin
      if (w_hs && aw_avail)  w_beat <= w_pop ? 8'd0 : w_beat + 8'd1;
      if (r_hs && !ar_empty) r_beat <= r_pop ? 8'd0 : r_beat + 8'd1;
      bpend       <= bpend + CW'(w_pop) - CW'(b_ok);
      wr_done_cnt <= wr_done_cnt + 32'(b_hs);
      rd_done_cnt <= rd_done_cnt + 32'(r_pop);
    end
  end

  // ---------------- payload stability ----------------
  logic [AXP-1:0] aw_pl, aw_pl_q, ar_pl, ar_pl_q;
  logic [WP-1:0]  w_pl, w_pl_q;
  logic [2:0]     st_v, st_r, st_vq, st_rq, st_chg;
  logic           armed;

  assign aw_pl  = {awaddr, awlen, awsize, awburst};
  assign ar_pl  = {araddr, arlen, arsize, arburst};
  assign w_pl   = {wdata, wstrb, wlast};
  assign st_v   = {arvalid, wvalid, awvalid};
  assign st_r   = {arready, wready, awready};
  assign st_chg = {ar_pl != ar_pl_q, w_pl != w_pl_q, aw_pl != aw_pl_q};

  // Previous-cycle snapshot; armed stays low for the first cycle out of reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      armed   <= 1'b0;
      st_vq   <= '0;
      st_rq   <= '0;
      aw_pl_q <= '0;
      ar_pl_q <= '0;
      w_pl_q  <= '0;
    end else begin
      armed   <= 1'b1;
      st_vq   <= st_v;
      st_rq   <= st_r;
      aw_pl_q <= aw_pl;
      ar_pl_q <= ar_pl;
      w_pl_q  <= w_pl;
    end
  end

  // ---------------- stall timeouts ----------------
  logic [NCH-1:0] ch_v, ch_r, to_hit;
  logic [TW-1:0]  to_cnt [NCH];

  assign ch_v = {rvalid, bvalid, wvalid, arvalid, awvalid};
  assign ch_r = {rready, bready, wready, arready, awready};

  for (genvar c = 0; c < NCH; c++) begin : g_to
    // Saturating stall counter; fires once as the stall reaches STALL_TIMEOUT cycles.
    always_ff @(posedge aclk) begin
      if (!aresetn)                 to_cnt[c] <= '0;
      else if (ch_v[c] && !ch_r[c]) begin
        if (to_cnt[c] != TW'(STALL_TIMEOUT)) to_cnt[c] <= to_cnt[c] + 1'b1;
      end else                      to_cnt[c] <= '0;
    end
    assign to_hit[c] = ch_v[c] && !ch_r[c] && (to_cnt[c] == TW'(STALL_TIMEOUT - 1));
  end

  // ---------------- error collection ----------------
  logic [NUM_CHK_ERR-1:0] new_err, err_base;

  // Violations detected at this edge.
  always_comb begin
    new_err = '0;
    for (int k = 0; k < 3; k++)
      new_err[k] = armed && st_vq[k] && !st_rq[k] && (!st_v[k] || st_chg[k]);
    new_err[ERR_WLAST]         = w_hs && aw_avail && (wlast != w_at_last);
    new_err[ERR_RLAST]         = r_hs && !ar_empty && (rlast != r_at_last);
    new_err[ERR_W_NO_AW]       = w_hs && !aw_avail;
    new_err[ERR_B_UNEXP]       = b_hs && (bpend == '0);
    new_err[ERR_R_UNEXP]       = r_hs && ar_empty;
    new_err[ERR_BURST_ILLEGAL] = (aw_hs && burst_bad(awburst, awlen, awsize, awaddr[6:0])) ||
                                 (ar_hs && burst_bad(arburst, arlen, arsize, araddr[6:0]));
    new_err[ERR_SIZE_ILLEGAL]  = (aw_hs && ((32'd1 << awsize) > 32'(DATA_WIDTH/8))) ||
                                 (ar_hs && ((32'd1 << arsize) > 32'(DATA_WIDTH/8)));
    new_err[ERR_OVERFLOW]      = aw_ovf || ar_ovf;
    new_err[ERR_TIMEOUT]       = |to_hit;
  end

  // Clear is applied before new bits, so a coincident error survives the clear.
  always_comb err_base = err_clr ? '0 : err_flags;

  // Sticky flags, first-error index and one-cycle pulse.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_flags <= '0;
      first_err <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_flags <= err_base | new_err;
      err_pulse <= |new_err;
      if ((|new_err) && (err_base == '0)) first_err <= first_idx(new_err);
      else if (err_clr)                   first_err <= '0;
    end
  end

  // Channel fields the checker taps but does not inspect.
  logic unused_taps;
  assign unused_taps = ^{bresp, rresp, rdata};

endmodule

// File: tb/tb_ei_axi4_protocol_checker.sv
// Directed bench for ei_axi4_protocol_checker (64-bit data, 8 outstanding, 16-cycle timeout).
module tb_ei_axi4_protocol_checker;
  localparam int DW = 64;
  localparam int AW = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, arvalid, arready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic          wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready, err_clr;
  logic [11:0]   err_flags;
  logic [3:0]    first_err;
  logic          err_pulse;
  logic [31:0]   wr_done_cnt, rd_done_cnt;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  ei_axi4_protocol_checker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(8),
                             .STALL_TIMEOUT(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err_clr(err_clr), .err_flags(err_flags), .first_err(first_err), .err_pulse(err_pulse),
    .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; returns 1 time unit after it so outputs are settled.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 0; awready = 0;
    wdata = '0; wstrb = '1; wlast = 0; wvalid = 0; wready = 0;
    bresp = '0; bvalid = 0; bready = 0;
    araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 0; arready = 0;
    rdata = '0; rresp = '0; rlast = 0; rvalid = 0; rready = 0;
    err_clr = 0;
  endtask

  task automatic do_reset();
    idle();
    aresetn = 0;
    step(); step();
    aresetn = 1;
  endtask

  task automatic aw_hs(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    awvalid = 1; awready = 1; awlen = len; awsize = size; awburst = burst; awaddr = 32'h100;
    step();
    awvalid = 0; awready = 0;
  endtask

  task automatic w_beat(input logic last);
    wvalid = 1; wready = 1; wlast = last; wdata = wdata + 1;
    step();
    wvalid = 0; wready = 0; wlast = 0;
  endtask

  task automatic b_hs();
    bvalid = 1; bready = 1;
    step();
    bvalid = 0; bready = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_flags", 32'(err_flags), 0);
    chk("rst_first", 32'(first_err), 0);
    chk("rst_pulse", 32'(err_pulse), 0);
    chk("rst_wr", wr_done_cnt, 0);
    chk("rst_rd", rd_done_cnt, 0);

    // Legal INCR write, len 3.
    aw_hs(8'd3, 3'd2, 2'b01);
    for (int b = 0; b < 4; b++) w_beat(b == 3);
    b_hs();
    step();
    chk("legal_flags", 32'(err_flags), 0);
    chk("legal_wr", wr_done_cnt, 1);
    chk("legal_pulse", 32'(err_pulse), 0);

    // Early wlast on beat 1, correct wlast on beat 3.
    do_reset();
    aw_hs(8'd3, 3'd2, 2'b01);
    w_beat(1'b0);
    w_beat(1'b1);
    chk("wlast_flags", 32'(err_flags), 32'h008);
    chk("wlast_first", 32'(first_err), 3);
    chk("wlast_pulse", 32'(err_pulse), 1);
    w_beat(1'b0);
    chk("wlast_pulse_end", 32'(err_pulse), 0);
    w_beat(1'b1);
    b_hs();
    err_clr = 1; step(); err_clr = 0;
    chk("clr_flags", 32'(err_flags), 0);
    aw_hs(8'd1, 3'd2, 2'b01);
    w_beat(1'b0);
    w_beat(1'b1);
    b_hs();
    chk("resync_flags", 32'(err_flags), 0);
    chk("resync_wr", wr_done_cnt, 2);

    // awaddr changes under back-pressure, then clear coinciding with a bad WRAP.
    do_reset();
    awvalid = 1; awready = 0; awaddr = 32'h100; awlen = 0;
    step();
    awaddr = 32'h104;
    step();
    chk("awstab_flags", 32'(err_flags), 32'h001);
    chk("awstab_first", 32'(first_err), 0);
    awready = 1;
    step();
    awvalid = 0; awready = 0;
    err_clr = 1; arvalid = 1; arready = 1; arburst = 2'b10; arlen = 8'd2; araddr = 32'h40;
    step();
    err_clr = 0; arvalid = 0; arready = 0;
    chk("clrwin_flags", 32'(err_flags), 32'h100);
    chk("clrwin_first", 32'(first_err), 8);

    // AR FIFO overflow, drain, then unexpected R.
    do_reset();
    arvalid = 1; arready = 1; arlen = 0; arburst = 2'b01;
    for (int i = 0; i < 8; i++) begin
      araddr = 32'(i * 4);
      step();
    end
    chk("ar8_flags", 32'(err_flags), 0);
    step();
    arvalid = 0; arready = 0;
    chk("ovf_flags", 32'(err_flags), 32'h400);
    chk("ovf_first", 32'(first_err), 10);
    err_clr = 1; step(); err_clr = 0;
    rvalid = 1; rready = 1; rlast = 1;
    for (int i = 0; i < 8; i++) step();
    chk("drain_flags", 32'(err_flags), 0);
    chk("drain_rd", rd_done_cnt, 8);
    step();
    rvalid = 0; rready = 0; rlast = 0;
    chk("runexp_flags", 32'(err_flags), 32'h080);
    chk("runexp_first", 32'(first_err), 7);

    // W stall timeout: quiet at 15 cycles, fires at 16, pulse once.
    do_reset();
    wvalid = 1; wready = 0; wdata = 64'h55;
    for (int i = 0; i < 15; i++) step();
    chk("stall15_flags", 32'(err_flags), 0);
    step();
    chk("stall16_flags", 32'(err_flags), 32'h800);
    chk("stall16_first", 32'(first_err), 11);
    chk("stall16_pulse", 32'(err_pulse), 1);
    step();
    chk("stall17_pulse", 32'(err_pulse), 0);

    // Size limit on a 64-bit bus, then a misaligned WRAP.
    do_reset();
    aw_hs(8'd0, 3'd3, 2'b01);
    chk("size3_flags", 32'(err_flags), 0);
    aw_hs(8'd0, 3'd4, 2'b01);
    chk("size4_flags", 32'(err_flags), 32'h200);
    chk("size4_first", 32'(first_err), 9);
    arvalid = 1; arready = 1; arburst = 2'b10; arlen = 8'd3; arsize = 3'd2; araddr = 32'h42;
    step();
    arvalid = 0; arready = 0;
    chk("wrapmis_flags", 32'(err_flags), 32'h300);
    chk("wrapmis_first", 32'(first_err), 9);

    // Pass-through write, then reset in the middle of a burst.
    do_reset();
    awvalid = 1; awready = 1; awlen = 0; wvalid = 1; wready = 1; wlast = 1;
    step();
    awvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0;
    b_hs();
    chk("pass_flags", 32'(err_flags), 0);
    chk("pass_wr", wr_done_cnt, 1);
    aw_hs(8'd3, 3'd2, 2'b01);
    w_beat(1'b0);
    w_beat(1'b0);
    arvalid = 1; arready = 1; arburst = 2'b11;
    step();
    arvalid = 0; arready = 0;
    chk("rsv_flags", 32'(err_flags), 32'h100);
    chk("rsv_pulse", 32'(err_pulse), 1);
    aresetn = 0; wvalid = 1; wready = 1;
    step();
    chk("midrst_flags", 32'(err_flags), 0);
    chk("midrst_first", 32'(first_err), 0);
    chk("midrst_pulse", 32'(err_pulse), 0);
    chk("midrst_wr", wr_done_cnt, 0);
    chk("midrst_rd", rd_done_cnt, 0);
    idle();
    aresetn = 1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
